// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable tick / divided-clock generator.
// Period and mode are captured at the start of each half-period, so changes are glitch-free.
module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 27
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pause,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] max,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow_max;
    logic             shadow_mode;
    logic [WIDTH-1:0] eff_max;
    logic             eff_mode;
    logic             term;

    // A fresh half-period uses the live inputs; otherwise the captured copy.
    assign eff_max  = (cnt == '0) ? max[g*WIDTH +: WIDTH] : shadow_max;
    assign eff_mode = (cnt == '0) ? mode[g] : shadow_mode;
    assign term     = (cnt >= eff_max);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt         <= '0;
        shadow_max  <= '0;
        shadow_mode <= 1'b0;
        clk_out[g]  <= 1'b0;
        tick[g]     <= 1'b0;
      end else if (load || !ch_en[g]) begin
        cnt        <= '0;
        clk_out[g] <= 1'b0;
        tick[g]    <= 1'b0;
      end else if (pause) begin
        tick[g] <= 1'b0;
      end else begin
        if (cnt == '0) begin
          shadow_max  <= max[g*WIDTH +: WIDTH];
          shadow_mode <= mode[g];
        end
        if (term) begin
          cnt        <= '0;
          tick[g]    <= 1'b1;
          clk_out[g] <= eff_mode ? 1'b1 : ~clk_out[g];
        end else begin
          cnt     <= cnt + WIDTH'(1);
          tick[g] <= 1'b0;
          if (eff_mode) clk_out[g] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed self-checking bench for clk_div_bank.
// Two channels, 8-bit periods.
module tb_clk_div_bank;
  localparam int CH = 2;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pause;
  logic          load;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] mode;
  logic [W-1:0]  max0;
  logic [W-1:0]  max1;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .pause   (pause),
    .load    (load),
    .ch_en   (ch_en),
    .mode    (mode),
    .max     ({max1, max0}),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    edge1();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; load = 1'b0;
    ch_en = 2'b11; mode = 2'b10;
    max0 = 8'd3; max1 = 8'd1;
    edge1();
    edge1();
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    #2 reset = 1'b0;

    // ch0 toggle max=3, ch1 pulse max=1
    for (int k = 1; k <= 40; k++) begin
      edge1();
      check("t1_tick0", tick[0], (k % 4) == 0);
      check("t1_clk0", clk_out[0], (k / 4) % 2);
      check("t1_tick1", tick[1], (k % 2) == 0);
      check("t1_clk1", clk_out[1], (k % 2) == 0);
    end

    // mid-count period change is deferred to the next wrap
    max0 = 8'd5; mode = 2'b00;
    do_load();
    check("t2_load_clk", clk_out, 0);
    check("t2_load_tick", tick, 0);
    for (int k = 1; k <= 12; k++) begin
      edge1();
      if (k == 2) max0 = 8'd1;
      check("t2_tick0", tick[0], (k >= 6) && (k % 2 == 0));
      check("t2_clk0", clk_out[0], (k >= 6 && k < 8) || (k >= 10 && k < 12));
    end

    // pause freezes count and clk_out, suppresses tick
    max0 = 8'd4;
    do_load();
    for (int k = 1; k <= 7; k++) begin
      edge1();
      check("t3_pre_tick", tick[0], k == 5);
      check("t3_pre_clk", clk_out[0], k >= 5);
    end
    pause = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge1();
      check("t3_p_tick", tick[0], 0);
      check("t3_p_clk", clk_out[0], 1);
    end
    pause = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      edge1();
      check("t3_r_tick", tick[0], k == 3);
      check("t3_r_clk", clk_out[0], k < 3);
    end

    // load aligns channels with different phases
    max1 = 8'd4;
    for (int k = 1; k <= 3; k++) edge1();
    do_load();
    check("t4_load_clk", clk_out, 0);
    check("t4_load_tick", tick, 0);
    for (int k = 1; k <= 5; k++) begin
      edge1();
      check("t4_tick", tick, (k == 5) ? 2'b11 : 2'b00);
      check("t4_clk", clk_out, (k == 5) ? 2'b11 : 2'b00);
    end
    pause = 1'b1;
    do_load();
    check("t4_pload_clk", clk_out, 0);
    pause = 1'b0;
    for (int k = 1; k <= 5; k++) edge1();
    check("t5_pre_clk", clk_out, 2'b11);
    check("t5_pre_tick", tick, 2'b11);

    // async reset between edges
    #2 reset = 1'b1;
    #1;
    check("t5_async_clk", clk_out, 0);
    check("t5_async_tick", tick, 0);
    max0 = 8'd0; max1 = 8'd0; mode = 2'b10;
    #2 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      check("t5_tick", tick, 2'b11);
      check("t5_clk0", clk_out[0], k % 2);
      check("t5_clk1", clk_out[1], 1);
    end

    // per-channel disable and re-enable
    max0 = 8'd3; max1 = 8'd2; mode = 2'b00; ch_en = 2'b01;
    do_load();
    for (int k = 1; k <= 8; k++) begin
      edge1();
      check("t6_tick0", tick[0], (k % 4) == 0);
      check("t6_clk0", clk_out[0], k >= 4 && k < 8);
      check("t6_off", {clk_out[1], tick[1]}, 0);
    end
    ch_en = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      edge1();
      check("t6_tick1", tick[1], k == 3);
      check("t6_clk1", clk_out[1], k >= 3);
      check("t6_tick0b", tick[0], k == 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
